// File: rtl/obstacle_speed_ctrl_pkg.sv
// dino_speed_pkg: shared states, fixed-point defaults and saturation helper for the obstacle speed scheduler
package dino_speed_pkg;
   typedef enum logic [1:0] {IDLE, RUN, OVER} state_t;
   localparam int FRAC_BITS = 4;
   localparam logic [3:0] LEVEL_MAX = 4'd15;
   function automatic int sat_add(input int a, input int b, input int max);
      return (a + b > max) ? max : a + b;
   endfunction
endpackage

// File: rtl/obstacle_speed_ctrl_if.sv
// obstacle_speed_ctrl_if: game events in, obstacle step/speed/level status out
interface obstacle_speed_ctrl_if #(parameter int SPEED_W = 6);
   logic                i_game_tick;
   logic                i_game_start;
   logic                i_game_over;
   logic [15:0]         i_score;
`ifdef OBS_SPEED_PAUSE_EN
   logic                i_pause;
`endif
   logic                o_step;
   logic [SPEED_W-1:0]  o_speed;
   logic [3:0]          o_level;
   logic                o_running;
   modport master (
`ifdef OBS_SPEED_PAUSE_EN
      output i_pause,
`endif
      output i_game_tick, i_game_start, i_game_over, i_score,
      input  o_step, o_speed, o_level, o_running
   );
   modport slave (
`ifdef OBS_SPEED_PAUSE_EN
      input  i_pause,
`endif
      input  i_game_tick, i_game_start, i_game_over, i_score,
      output o_step, o_speed, o_level, o_running
   );
endinterface

// File: rtl/obstacle_speed_ctrl_emitter.sv
// obs_step_emitter: saturating pending-step counter that drains one registered step pulse per clock
module obs_step_emitter
   import dino_speed_pkg::*;
#(
   parameter int PEND_W = 3,
   parameter int ADD_W  = 6
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [ADD_W-1:0] add,
   input  logic             add_stb,
   input  logic             hold,
   input  logic             clear,
   output logic             step
);
   logic [PEND_W-1:0] pending;
   logic              dec;
   assign dec = (pending != '0) && !hold;
   // drain one pending step per clock while accepting new steps from a tick in the same cycle
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pending <= '0;
         step    <= 1'b0;
      end else if (clear) begin
         pending <= '0;
         step    <= 1'b0;
      end else begin
         step    <= dec;
         pending <= PEND_W'(sat_add(int'(pending) - int'(dec), add_stb ? int'(add) : 0, (1 << PEND_W) - 1));
      end
   end
endmodule

// File: rtl/obstacle_speed_ctrl.sv
// obstacle_speed_ctrl: fixed-point scroll-rate scheduler turning game ticks into obstacle step pulses; OBS_SPEED_PAUSE_EN adds i_pause
module obstacle_speed_ctrl
   import dino_speed_pkg::*;
#(
   parameter int FRAC_BITS  = dino_speed_pkg::FRAC_BITS,
   parameter int SPEED_W    = 6,
   parameter int SPEED_INIT = 16,
   parameter int SPEED_INC  = 2,
   parameter int SPEED_MAX  = 48,
   parameter int PEND_W     = 3
) (
   input  logic                  clk,
   input  logic                  rst,
   obstacle_speed_ctrl_if.slave  bus
);
   state_t                        state, state_nx;
   logic [SPEED_W-1:0]            speed;
   logic [FRAC_BITS-1:0]          acc;
   logic [3:0]                    level;
   logic [3:0]                    prev_hund;
   logic [3:0]                    hund;
   logic [FRAC_BITS+SPEED_W-1:0]  sum;
   logic                          pause, start_ev, run_act, tick_now, lvl_up;
`ifdef OBS_SPEED_PAUSE_EN
   assign pause = bus.i_pause;
`else
   assign pause = 1'b0;
`endif
   assign hund     = bus.i_score[11:8];
   assign start_ev = (state != RUN) && bus.i_game_start && !bus.i_game_over;
   assign run_act  = (state == RUN) && !bus.i_game_over && !pause;
   assign tick_now = run_act && bus.i_game_tick;
   assign lvl_up   = run_act && (hund != prev_hund);
   assign sum      = (FRAC_BITS+SPEED_W)'(acc) + (FRAC_BITS+SPEED_W)'(speed);
   // game state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end
   // game flow: over beats a simultaneous start
   always_comb begin
      state_nx = state;
      if (start_ev) state_nx = RUN;
      else if (state == RUN && bus.i_game_over) state_nx = OVER;
   end
   // speed ramp, fractional accumulator and level tracking; a tick uses the speed held before any same-cycle level-up
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         speed     <= SPEED_W'(SPEED_INIT);
         acc       <= '0;
         level     <= '0;
         prev_hund <= '0;
      end else begin
         prev_hund <= hund;
         if (start_ev) begin
            speed <= SPEED_W'(SPEED_INIT);
            acc   <= '0;
            level <= '0;
         end else begin
            if (tick_now) acc <= sum[FRAC_BITS-1:0];
            if (lvl_up) begin
               speed <= SPEED_W'(sat_add(int'(speed), SPEED_INC, SPEED_MAX));
               level <= 4'(sat_add(int'(level), 1, int'(LEVEL_MAX)));
            end
         end
      end
   end
   obs_step_emitter #(.PEND_W(PEND_W), .ADD_W(SPEED_W)) u_emit (
      .clk     (clk),
      .rst     (rst),
      .add     (sum[FRAC_BITS +: SPEED_W]),
      .add_stb (tick_now),
      .hold    (pause),
      .clear   ((state != RUN) || bus.i_game_over),
      .step    (bus.o_step)
   );
   assign bus.o_speed   = speed;
   assign bus.o_level   = level;
   assign bus.o_running = (state == RUN);
endmodule
